// File: rtl/ahb_hex_display.sv
// ahb_hex_display: AHB-Lite slave scanning a 32-bit word onto an 8-digit seven-segment display.
// Define HEX_DISPLAY_READBACK_EN to make DisplayData/Control readable; otherwise reads return 0.
module ahb_hex_display #(
  parameter int SCAN_DIVIDE = 50000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [6:0]  Segments,
  output logic        DecimalPoint,
  output logic [7:0]  DigitSelect
);
  localparam int CW = SCAN_DIVIDE > 1 ? $clog2(SCAN_DIVIDE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIVIDE - 1);
  logic          sel, show;
  logic          we_q, we_d, re_q, re_d, wa_q, wa_d;
  logic [31:0]   disp_q, disp_d;
  logic [16:0]   ctrl_q, ctrl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    nib;
  logic [6:0]    glyph, seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [7:0]    dsel_q, dsel_d;
  always_comb begin
    sel    = HREADY && HSEL && HTRANS != 2'b00;
    we_d   = sel && HWRITE;
    re_d   = sel && !HWRITE;
    wa_d   = sel && HADDR[2];
    disp_d = (we_q && !wa_q) ? HWDATA : disp_q;
    ctrl_d = (we_q && wa_q) ? HWDATA[16:0] : ctrl_q;
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    idx_d  = (cnt_q == LAST) ? idx_q + 3'd1 : idx_q;
    nib    = disp_q[{idx_q, 2'b00} +: 4];
    show   = !ctrl_q[16] && ctrl_q[idx_q];
    dsel_d = show ? ~(8'd1 << idx_q) : 8'hFF;
    seg_d  = show ? glyph : 7'h7F;
    dp_d   = show ? ~ctrl_q[{1'b1, idx_q}] : 1'b1;
  end
  // Active-low glyphs, bit0=a .. bit6=g; b and d are lowercase
  always_comb begin
    glyph = 7'h7F;
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      wa_q   <= 1'b0;
      disp_q <= '0;
      ctrl_q <= 17'h000FF;
      cnt_q  <= '0;
      idx_q  <= '0;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      dsel_q <= 8'hFF;
    end else begin
      we_q   <= we_d;
      re_q   <= re_d;
      wa_q   <= wa_d;
      disp_q <= disp_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dsel_q <= dsel_d;
    end
  end
`ifdef HEX_DISPLAY_READBACK_EN
  assign HRDATA = !re_q ? '0 : wa_q ? {15'd0, ctrl_q} : disp_q;
`else
  assign HRDATA = '0;
`endif
  assign HREADYOUT    = 1'b1;
  assign Segments     = seg_q;
  assign DecimalPoint = dp_q;
  assign DigitSelect  = dsel_q;
endmodule

// File: tb/tb_ahb_hex_display.sv
// tb_ahb_hex_display: randomized AHB traffic with a queue scoreboard against an arithmetic display model.
module tb_ahb_hex_display;
  logic HCLK = 0, HRESETn = 0;
  logic [31:0] HADDR = 0, HWDATA = 0;
  logic [2:0] HSIZE = 3'b010;
  logic [1:0] HTRANS = 0;
  logic HWRITE = 0, HREADY = 1, HSEL = 0;
  logic [31:0] rd4, rd1;
  logic ro4, ro1, dp4, dp1;
  logic [6:0] sg4, sg1;
  logic [7:0] ds4, ds1;
  always #5 HCLK = ~HCLK;
  ahb_hex_display #(.SCAN_DIVIDE(4)) dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HRDATA(rd4),
    .HREADYOUT(ro4), .Segments(sg4), .DecimalPoint(dp4), .DigitSelect(ds4));
  ahb_hex_display #(.SCAN_DIVIDE(1)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HRDATA(rd1),
    .HREADYOUT(ro1), .Segments(sg1), .DecimalPoint(dp1), .DigitSelect(ds1));
  // Lit segments per hex glyph, as letters a..g
  string glyphs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] m_disp = 0, pend_wd = 0;
  logic [16:0] m_ctrl = 17'hFF;
  logic p_w = 0, p_a = 0, p_r = 0, m_sel;
  logic [15:0] q4 [$], q1 [$];
  logic [31:0] rq [$];
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] m;
    string s;
    m = 7'h7F;
    s = glyphs[v];
    for (int j = 0; j < s.len(); j++) m[int'(s[j]) - 97] = 1'b0;
    return m;
  endfunction
  // Digit shown after the (c+1)-th edge out of reset is (c / n) mod 8
  function automatic logic [15:0] expect_out(input int c, input int n);
    int i;
    i = (c / n) % 8;
    if (m_ctrl[16] || !m_ctrl[i]) return {8'hFF, 7'h7F, 1'b1};
    return {~(8'h01 << i), glyph(m_disp[4*i +: 4]), ~m_ctrl[8+i]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) begin
      cyc = 0; m_disp = 0; m_ctrl = 17'hFF; p_w = 0; p_a = 0; p_r = 0;
      q4.delete(); q1.delete(); rq.delete();
    end else begin
      q4.push_back(expect_out(cyc, 4));
      q1.push_back(expect_out(cyc, 1));
      if (p_w) begin
        if (p_a) m_ctrl = HWDATA[16:0];
        else m_disp = HWDATA;
      end
      m_sel = HSEL && HREADY && HTRANS != 2'b00;
      p_w = m_sel && HWRITE;
      p_r = m_sel && !HWRITE;
      p_a = HADDR[2];
`ifdef HEX_DISPLAY_READBACK_EN
      rq.push_back(p_r ? (p_a ? {15'd0, m_ctrl} : m_disp) : 32'd0);
`else
      rq.push_back(32'd0);
`endif
      cyc++;
    end
  end
  initial forever begin
    @(negedge HCLK);
    if (!HRESETn) begin
      check("rst_dsel", {24'd0, ds4}, 32'hFF);
      check("rst_seg", {25'd0, sg4}, 32'h7F);
      check("rst_dp", {31'd0, dp4}, 32'd1);
      check("rst_hrdata", rd4, 32'd0);
      check("rst_hreadyout", {31'd0, ro4}, 32'd1);
      check("rst_dsel_div1", {24'd0, ds1}, 32'hFF);
    end else if (q4.size() == 0 || q1.size() == 0 || rq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      check("display_div4", {16'd0, ds4, sg4, dp4}, {16'd0, q4.pop_front()});
      check("display_div1", {16'd0, ds1, sg1, dp1}, {16'd0, q1.pop_front()});
      check("hrdata_div4", rd4, rq[0]);
      check("hrdata_div1", rd1, rq.pop_front());
      check("hreadyout", {31'd0, ro4 & ro1}, 32'd1);
    end
  end
  task automatic bus(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd, input logic rdy = 1'b1);
    @(negedge HCLK);
    HWDATA = pend_wd;
    HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HREADY = rdy;
    pend_wd = wr ? wd : 32'd0;
  endtask
  task automatic idle(input int n);
    repeat (n) bus(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask
  initial begin
    logic [31:0] d, a;
    repeat (3) @(negedge HCLK);
    #1 HRESETn = 1;
    idle(40);
    bus(1, 2'b10, 1, 32'h0, 32'h0123ABCD); idle(40);
    bus(1, 2'b10, 1, 32'h4, 32'h00010000); idle(40);
    bus(1, 2'b10, 1, 32'h4, 32'h00000201); idle(40);
    bus(1, 2'b10, 1, 32'h4, 32'h00000302); idle(40);
    bus(1, 2'b10, 1, 32'h4, 32'h000000FF);
    bus(0, 2'b10, 1, 32'h0, 32'hFFFFFFFF);
    bus(1, 2'b00, 1, 32'h0, 32'hFFFFFFFF);
    idle(40);
    bus(1, 2'b10, 1, 32'h4, 32'hFFFFFFFF);
    bus(1, 2'b10, 0, 32'h4, 32'h0);
    bus(1, 2'b10, 1, 32'h0, 32'h89ABCDEF);
    bus(1, 2'b11, 0, 32'h0, 32'h0);
    idle(2);
    for (int k = 0; k < 300; k++) begin
      a = $urandom_range(0, 1) ? 32'h4 : 32'h0;
      a = a | ($urandom & 32'hFFFF_FFF0);
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[16] = 1'b0;
      bus($urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, d, $urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
    end
    idle(2);
    @(posedge HCLK);
    #1 HRESETn = 0;
    repeat (2) @(negedge HCLK);
    #1 HRESETn = 1;
    idle(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
